fp16_add_sched: RTL and testbench
=================================

Name: fp16_add_sched

Overview:
Round-robin scheduler that shares one 3-stage float16 adder pipeline (fixed 3-cycle latency, no stall) between NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle. It tags each issue with the requester index, tracks it through the pipeline, and returns the adder result with that tag. It also supports a hold/drain control for quiescing the adder.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester index width, equals clog2(NUM_REQ)
LATENCY, 3, adder latency in clocks from operand presentation to registered z

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_x  input  16*NUM_REQ  operand x, requester i in bits [16i+15:16i]
req_y  input  16*NUM_REQ  operand y, same packing
add_x  output  16  operand x to adder
add_y  output  16  operand y to adder
add_counter  output  3  adder evaluate control; adder computes only when 0
add_z  input  16  adder result (registered in adder)
rsp_valid  output  1  result valid this cycle
rsp_id  output  ID_W  requester index owning rsp_z
rsp_z  output  16  result, equals add_z
hold  input  1  stop issuing new operations
idle  output  1  no operation in flight and none issuing

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: rr_ptr=NUM_REQ-1, valid pipe all 0, id pipe 0, outstanding=0, state=IDLE. Outputs under reset: req_ready=0, rsp_valid=0, rsp_id=0, idle=1.
- Arbitration (combinational):
  - Search starts at index rr_ptr+1, mod NUM_REQ.
  - The first i with req_valid[i]=1 is granted; req_ready[i]=1 only if hold=0.
  - Issue = any bit of (req_valid & req_ready). At most one bit is set.
- Issue cycle: add_x/add_y = req_x/req_y of the granted requester. No issue: add_x=add_y=16'h0000 (adder yields 0, never flagged valid).
- add_counter: constant 3'd0 out of reset, so the adder evaluates every cycle.
- rr_ptr update: loads the granted index on issue; unchanged otherwise. A requester holding valid low is skipped without penalty.
- Tracking: shift registers vld_pipe[LATENCY], id_pipe[LATENCY].
  - Stage 0 loads issue and the grant index.
  - rsp_valid = vld_pipe[LATENCY-1]; rsp_id = id_pipe[LATENCY-1]; rsp_z = add_z.
  - Issue at cycle t gives rsp_valid in cycle t+3.
- Responses have no backpressure: the requester must accept in the cycle rsp_valid=1. Back-to-back issues give back-to-back responses, in issue order.
- outstanding counter (0..LATENCY): +1 on issue, -1 on rsp_valid, unchanged when both occur. It never exceeds LATENCY.
- FSM:
  - IDLE: outstanding=0 and no issue; idle=1. Issue → BUSY.
  - BUSY: hold=1 → DRAIN. outstanding reaching 0 with no issue → IDLE.
  - DRAIN: req_ready forced 0. outstanding=0 → IDLE. hold deasserted while outstanding>0 → BUSY.
  - hold=1 in IDLE keeps IDLE with req_ready=0.
- idle = (state==IDLE) and no issue this cycle; combinational.
- Simultaneous issue and rsp_valid is legal every cycle.
- Reset mid-operation: in-flight results are discarded. rsp_valid is forced 0 immediately, with no spurious valid after reset release, even though the adder pipeline still holds data.
- Requesters must hold req_x/req_y stable while req_valid=1 and not yet accepted.

Optional Feature:
Macro FP16_ADD_SCHED_PERF_EN.
- Defined: adds output perf_issue_cnt (32 bits), a wrapping count of issues. Also adds output perf_stall_cnt (32 bits), a wrapping count of cycles with any req_valid=1 but no issue. Both reset to 0 asynchronously.
- Not defined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Single request: req0 x=0x3C00, y=0x3C00, issued cycle t → rsp_valid at t+3 with rsp_id=0, rsp_z=0x4000; idle returns to 1 at t+4.
- All 4 requesters valid continuously (requester i: x=0x4000, y=0x3C00) → grants 0,1,2,3,0… one per cycle; responses every cycle from t+3, rsp_z=0x4200, rsp_id sequence 0,1,2,3.
- req1 and req3 only valid → grants alternate 1,3,1,3 with no idle cycles; req0 and req2 never get req_ready.
- hold asserted one cycle after 2 issues → req_ready=0 immediately; 2 responses still arrive; idle=1 once outstanding=0; release hold → issue resumes from rr_ptr+1.
- reset asserted with 3 operations in flight → rsp_valid=0 and idle=1 during and after reset; no response emitted for the lost operations.
- With FP16_ADD_SCHED_PERF_EN: 5 issues plus 2 cycles of hold with valid high → perf_issue_cnt=5, perf_stall_cnt=2.

Source files
------------

// File: rtl/fp16_add_sched_if.sv
// Bundle of requester, adder and response signals for fp16_add_sched.
// slave: scheduler side. master: requesters, adder and response sink.
interface fp16_add_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_x;
  logic [16*NUM_REQ-1:0] req_y;
  logic [15:0]           add_x;
  logic [15:0]           add_y;
  logic [2:0]            add_counter;
  logic [15:0]           add_z;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_z;
  logic                  hold;
  logic                  idle;

  modport slave (
    input  req_valid, req_x, req_y, add_z, hold,
    output req_ready, add_x, add_y, add_counter, rsp_valid, rsp_id, rsp_z, idle
  );

  modport master (
    output req_valid, req_x, req_y, add_z, hold,
    input  req_ready, add_x, add_y, add_counter, rsp_valid, rsp_id, rsp_z, idle
  );
endinterface

// File: rtl/fp16_add_sched.sv
// Round-robin scheduler sharing one fixed-latency fp16 adder among NUM_REQ requesters.
// Define FP16_ADD_SCHED_PERF_EN to add issue/stall performance counters.
module fp16_add_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 3
) (
  input  logic            clk,
  input  logic            reset,
  fp16_add_sched_if.slave io_bus
`ifdef FP16_ADD_SCHED_PERF_EN
  ,
  output logic [31:0]     o_perf_issue_cnt,
  output logic [31:0]     o_perf_stall_cnt
`endif
);

  localparam int OUT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [LATENCY-1:0] r_vld_pipe;
  logic [ID_W-1:0]    r_id_pipe [LATENCY];
  logic [OUT_W-1:0]   r_outstanding;
  logic [OUT_W-1:0]   w_out_nxt;
  logic               w_grant_found;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_allow;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_issue;
  logic [15:0]        w_add_x;
  logic [15:0]        w_add_y;
  logic               w_rsp_valid;

  // Requester index reached by stepping offset places past ptr, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] ptr, input int offset);
    int idx;
    idx = (int'(ptr) + offset) % NUM_REQ;
    return ID_W'(idx);
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_grant_found && io_bus.req_valid[rr_index(r_rr_ptr, k)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = rr_index(r_rr_ptr, k);
      end else begin
        w_grant_found = w_grant_found;
      end
    end
  end

  // Reset also blocks grants so nothing issues while the tracking pipe is cleared.
  assign w_allow = !reset && !io_bus.hold && (r_state != ST_DRAIN);

  // One-hot ready toward the granted requester, or zero.
  always_comb begin
    w_ready = '0;
    if (w_grant_found && w_allow) begin
      w_ready[w_grant_idx] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  assign w_issue = |(io_bus.req_valid & w_ready);

  // Operand mux; zeros when idle so the adder output is harmless.
  always_comb begin
    w_add_x = 16'h0000;
    w_add_y = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_issue && (w_grant_idx == ID_W'(i))) begin
        w_add_x = io_bus.req_x[16*i +: 16];
        w_add_y = io_bus.req_y[16*i +: 16];
      end else begin
        w_add_x = w_add_x;
        w_add_y = w_add_y;
      end
    end
  end

  assign w_rsp_valid = r_vld_pipe[LATENCY-1];

  // In-flight count: issue and response in the same cycle cancel out.
  always_comb begin
    case ({w_issue, w_rsp_valid})
      2'b10:   w_out_nxt = r_outstanding + OUT_W'(1);
      2'b01:   w_out_nxt = r_outstanding - OUT_W'(1);
      default: w_out_nxt = r_outstanding;
    endcase
  end

  // Next-state logic; IDLE always coincides with an empty adder pipeline.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if ((w_out_nxt == '0) && !w_issue) begin
          w_state_nxt = ST_IDLE;
        end else if (io_bus.hold) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DRAIN: begin
        if (w_out_nxt == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (!io_bus.hold) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, round-robin pointer and outstanding counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= ID_W'(NUM_REQ - 1);
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      if (w_issue) begin
        r_rr_ptr <= w_grant_idx;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // Valid/tag shift registers aligned with the adder stages; cleared on reset
  // so stale adder data is never flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_id_pipe[i] <= '0;
      end
    end else begin
      r_vld_pipe[0] <= w_issue;
      r_id_pipe[0]  <= w_grant_idx;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_id_pipe[i]  <= r_id_pipe[i-1];
      end
    end
  end

  assign io_bus.req_ready   = w_ready;
  assign io_bus.add_x       = w_add_x;
  assign io_bus.add_y       = w_add_y;
  assign io_bus.add_counter = 3'd0;
  assign io_bus.rsp_valid   = w_rsp_valid;
  assign io_bus.rsp_id      = r_id_pipe[LATENCY-1];
  assign io_bus.rsp_z       = io_bus.add_z;
  assign io_bus.idle        = (r_state == ST_IDLE) && !w_issue;

`ifdef FP16_ADD_SCHED_PERF_EN
  logic [31:0] r_perf_issue_cnt;
  logic [31:0] r_perf_stall_cnt;

  // Wrapping issue count and count of cycles where demand existed but nothing issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_issue_cnt <= 32'd0;
      r_perf_stall_cnt <= 32'd0;
    end else begin
      if (w_issue) begin
        r_perf_issue_cnt <= r_perf_issue_cnt + 32'd1;
      end else begin
        r_perf_issue_cnt <= r_perf_issue_cnt;
      end
      if ((|io_bus.req_valid) && !w_issue) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end else begin
        r_perf_stall_cnt <= r_perf_stall_cnt;
      end
    end
  end

  assign o_perf_issue_cnt = r_perf_issue_cnt;
  assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_fp16_add_sched.sv
// Bench for fp16_add_sched: directed phases then random traffic, checked against
// a queue-based reference of grants, responses, idle and (optionally) perf counts.
module tb_fp16_add_sched;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp16_add_sched_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

`ifdef FP16_ADD_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fp16_add_sched #(.NUM_REQ(N), .ID_W(IDW), .LATENCY(LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
`ifdef FP16_ADD_SCHED_PERF_EN
    ,
    .o_perf_issue_cnt (perf_issue_cnt),
    .o_perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Small integer-valued fp16 helpers (values 0..16 are exact).
  function automatic int fp_dec(input logic [15:0] h);
    int e;
    if (h[14:10] == 5'd0) return 0;
    e = int'(h[14:10]) - 15;
    return (1024 + int'(h[9:0])) >> (10 - e);
  endfunction

  function automatic logic [15:0] fp_enc(input int n);
    int e;
    logic [15:0] r;
    if (n <= 0) return 16'h0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    r[15]    = 1'b0;
    r[14:10] = 5'(e + 15);
    r[9:0]   = 10'((n - (1 << e)) << (10 - e));
    return r;
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    return fp_enc(fp_dec(a) + fp_dec(b));
  endfunction

  // Behavioural 3-stage adder: operands in, registered sum out three edges later.
  logic [15:0] a1x = 16'h0, a1y = 16'h0, a2x = 16'h0, a2y = 16'h0;
  always @(posedge clk) begin
    a1x        <= bus.add_x;
    a1y        <= bus.add_y;
    a2x        <= a1x;
    a2y        <= a1y;
    bus.add_z  <= fp_add(a2x, a2y);
  end

  typedef struct {
    int          due;
    int          id;
    logic [15:0] z;
  } exp_t;

  exp_t        q[$];
  int          m_rr;
  bit          m_drain;
  int          m_issue_cnt;
  int          m_stall_cnt;
  int          cyc;
  int          checks;
  int          errors;
  logic [15:0] px[N];
  logic [15:0] py[N];
  logic [N-1:0] arm_mask;
  bit          rnd;
  logic [15:0] fx;
  logic [15:0] fy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.req_x[16*i +: 16] = px[i];
      bus.req_y[16*i +: 16] = py[i];
    end
  endtask

  // Raise valid on idle requesters in arm_mask; pending ones keep their operands.
  task automatic arm();
    for (int i = 0; i < N; i++) begin
      if (!bus.req_valid[i] && arm_mask[i] && (!rnd || ($urandom_range(2, 0) == 0))) begin
        bus.req_valid[i] = 1'b1;
        if (rnd) begin
          px[i] = fp_enc(int'($urandom_range(8, 0)));
          py[i] = fp_enc(int'($urandom_range(8, 0)));
        end else begin
          px[i] = fx;
          py[i] = fy;
        end
      end
    end
    pack();
  endtask

  // One clock: predict and check this cycle at negedge, advance model, drive next inputs.
  task automatic step();
    int          g;
    logic [N-1:0] er;
    bit          iss;
    bit          ev;
    bit          eidle;
    int          eid;
    logic [15:0] ez;
    logic [15:0] ex;
    logic [15:0] ey;
    @(negedge clk);
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (g < 0 && bus.req_valid[i]) g = i;
    end
    er = '0;
    if (g >= 0 && !bus.hold && !m_drain) er[g] = 1'b1;
    iss = (er != '0);
    ex = 16'h0000;
    ey = 16'h0000;
    if (iss) begin
      ex = px[g];
      ey = py[g];
    end
    eidle = (q.size() == 0) && !iss;
    ev = 1'b0;
    eid = 0;
    ez = 16'h0000;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev  = 1'b1;
      eid = q[0].id;
      ez  = q[0].z;
      void'(q.pop_front());
    end
    check("req_ready", 32'(bus.req_ready), 32'(er));
    check("add_x", 32'(bus.add_x), 32'(ex));
    check("add_y", 32'(bus.add_y), 32'(ey));
    check("add_counter", 32'(bus.add_counter), 32'd0);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    check("idle", 32'(bus.idle), 32'(eidle));
    if (ev) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(eid));
      check("rsp_z", 32'(bus.rsp_z), 32'(ez));
    end
    if (iss) begin
      q.push_back('{cyc + LAT, g, fp_add(px[g], py[g])});
      m_rr = g;
      m_issue_cnt++;
    end
    if ((|bus.req_valid) && !iss) m_stall_cnt++;
    m_drain = bus.hold && (q.size() > 0);
    @(posedge clk);
    cyc++;
    #1;
    if (iss) bus.req_valid[g] = 1'b0;
    arm();
    if (rnd && ($urandom_range(5, 0) == 0)) bus.hold = ~bus.hold;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_idle", 32'(bus.idle), 32'd1);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      @(posedge clk);
      cyc++;
      #1;
    end
    reset = 1'b0;
    q.delete();
    m_rr = N - 1;
    m_drain = 1'b0;
    m_issue_cnt = 0;
    m_stall_cnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.hold = 1'b0;
    for (int i = 0; i < N; i++) begin
      px[i] = 16'h0000;
      py[i] = 16'h0000;
    end
    arm_mask = '0;
    rnd = 1'b0;
    fx = 16'h0000;
    fy = 16'h0000;
    cyc = 0;
    checks = 0;
    errors = 0;
    do_reset(2);

    // Single request from requester 0: 1.0 + 1.0.
    px[0] = 16'h3C00;
    py[0] = 16'h3C00;
    pack();
    bus.req_valid[0] = 1'b1;
    repeat (6) step();

    // All requesters continuously valid: 2.0 + 1.0 each.
    fx = 16'h4000;
    fy = 16'h3C00;
    arm_mask = 4'b1111;
    arm();
    repeat (12) step();
    arm_mask = 4'b0000;
    repeat (8) step();

    // Only requesters 1 and 3.
    arm_mask = 4'b1010;
    arm();
    repeat (10) step();
    arm_mask = 4'b0000;
    repeat (8) step();

    // Two issues, then hold for several cycles, then release.
    arm_mask = 4'b1111;
    arm();
    repeat (2) step();
    bus.hold = 1'b1;
    repeat (6) step();
    bus.hold = 1'b0;
    repeat (6) step();

    // Reset with three operations in flight; none may come back.
    repeat (3) step();
    do_reset(3);
    arm_mask = 4'b0000;
    bus.req_valid = '0;
    repeat (6) step();

    // Random traffic with random hold toggling.
    rnd = 1'b1;
    arm_mask = 4'b1111;
    repeat (500) step();
    rnd = 1'b0;
    bus.hold = 1'b0;
    arm_mask = 4'b0000;
    repeat (12) step();

`ifdef FP16_ADD_SCHED_PERF_EN
    check("perf_issue_cnt", perf_issue_cnt, 32'(m_issue_cnt));
    check("perf_stall_cnt", perf_stall_cnt, 32'(m_stall_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
